// File: rtl/wb_pkg.sv
// Shared types for the Wishbone initiator: FSM state encoding and the
// 69-bit command record that travels through the command FIFO.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_GAP  = 2'd2
    } wb_state_t;

    typedef struct packed {
        logic        we;
        logic [3:0]  sel;
        logic [31:0] adr;
        logic [31:0] dat;
    } wb_cmd_t;

    localparam int CMD_W = $bits(wb_cmd_t);

endpackage

// File: rtl/wb_cmd_fifo.sv
// Synchronous command FIFO. Pointers carry one extra wrap bit so that
// full and empty are distinguished without a separate occupancy counter.
module wb_cmd_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = CMD_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = (AW+1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/wb_initiator.sv
// Wishbone classic single-transfer initiator: queues commands, runs one bus
// cycle per command and returns a one-cycle response pulse (data or timeout).
module wb_initiator
    import wb_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    // Command port: a command transfers on any rising edge where cmd_valid and
    // cmd_ready are both high; the offerer holds cmd_* stable until then.
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [3:0]  cmd_sel,
    input  logic [31:0] cmd_adr,
    input  logic [31:0] cmd_dat,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [31:0] rsp_dat,
    output logic        busy,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [3:0]  wbm_sel_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    output wb_state_t   dbg_state
);

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] T_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);

    wb_state_t           state_q, state_d;
    logic                cyc_q, cyc_d;
    wb_cmd_t             out_q, out_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic                rsp_err_q, rsp_err_d;
    logic [31:0]         rsp_dat_q, rsp_dat_d;

    logic                fifo_full;
    logic                fifo_empty;
    logic                pop;
    wb_cmd_t             cmd_in;
    logic [CMD_W-1:0]    head_bits;
    wb_cmd_t             head;

    assign cmd_in = '{we: cmd_we, sel: cmd_sel, adr: cmd_adr, dat: cmd_dat};
    assign head   = wb_cmd_t'(head_bits);

    wb_cmd_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (wb_clk_i),
        .reset     (wb_rst_i),
        .push      (cmd_valid),
        .push_data (cmd_in),
        .pop       (pop),
        .pop_data  (head_bits),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_q;
        out_d       = out_q;
        cnt_d       = cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_dat_d   = '0;
        pop         = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    out_d   = head;
                    cyc_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = ST_BUS;
                end
            end
            ST_BUS: begin
                if (wbm_ack_i) begin
                    cyc_d       = 1'b0;
                    state_d     = ST_GAP;
                    rsp_valid_d = 1'b1;
                    rsp_dat_d   = out_q.we ? 32'h0 : wbm_dat_i;
                end else if ((TIMEOUT != 0) && (cnt_q == T_LAST)) begin
                    cyc_d       = 1'b0;
                    state_d     = ST_GAP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            // One dead cycle swallows a registered ack that lingers after cyc drops.
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cyc_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            cyc_q       <= 1'b0;
            out_q       <= '0;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_dat_q   <= '0;
        end else begin
            state_q     <= state_d;
            cyc_q       <= cyc_d;
            out_q       <= out_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_dat_q   <= rsp_dat_d;
        end
    end

    assign cmd_ready = !fifo_full;
    assign busy      = !fifo_empty || (state_q != ST_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_dat   = rsp_dat_q;
    assign wbm_cyc_o = cyc_q;
    assign wbm_stb_o = cyc_q;
    assign wbm_we_o  = out_q.we;
    assign wbm_sel_o = out_q.sel;
    assign wbm_adr_o = out_q.adr;
    assign wbm_dat_o = out_q.dat;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_initiator.sv
// Bench for wb_initiator: directed scenarios plus randomized traffic against a
// behavioural responder, checked every cycle by a transaction-level model.
module tb_wb_initiator
    import wb_pkg::*;
;

    localparam int DEPTH = 4;
    localparam int TMO   = 8;

    logic        clk = 1'b0;
    logic        wb_rst_i = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [3:0]  cmd_sel = '0;
    logic [31:0] cmd_adr = '0;
    logic [31:0] cmd_dat = '0;
    logic        rsp_valid, rsp_err, busy;
    logic [31:0] rsp_dat;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [3:0]  wbm_sel_o;
    logic [31:0] wbm_adr_o, wbm_dat_o;
    logic [31:0] wbm_dat_i = '0;
    logic        wbm_ack_i = 1'b0;
    wb_state_t   dbg_state;

    int checks = 0;
    int failures = 0;
    int rsp_seen = 0;

    // responder controls
    int dly_lo = 0, dly_hi = 0, stale_mode = 0;

    wb_initiator #(.DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
        .wb_clk_i (clk),       .wb_rst_i (wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_we   (cmd_we),    .cmd_sel  (cmd_sel),
        .cmd_adr  (cmd_adr),   .cmd_dat  (cmd_dat),
        .rsp_valid(rsp_valid), .rsp_err  (rsp_err),
        .rsp_dat  (rsp_dat),   .busy     (busy),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
        .wbm_we_o (wbm_we_o),  .wbm_sel_o(wbm_sel_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i),
        .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] sel);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (sel[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    function automatic logic unmapped(input logic [31:0] adr);
        return adr[11:8] == 4'h3;
    endfunction

    // ---------------- responder (registered ack) ----------------
    logic [31:0] resp_mem [64];
    initial begin
        int wait_cnt, cur_delay, stale_left;
        logic s_rst, s_cyc, s_we;
        logic [3:0] s_sel;
        logic [31:0] s_adr, s_dat;
        for (int i = 0; i < 64; i++) resp_mem[i] = '0;
        wait_cnt = 0; cur_delay = 0; stale_left = 0;
        forever begin
            @(posedge clk);
            s_rst = wb_rst_i; s_cyc = wbm_cyc_o && wbm_stb_o; s_we = wbm_we_o;
            s_sel = wbm_sel_o; s_adr = wbm_adr_o; s_dat = wbm_dat_o;
            #1;
            if (s_rst) begin
                wbm_ack_i = 1'b0; wait_cnt = 0; stale_left = 0;
            end else if (wbm_ack_i) begin
                if (stale_left > 0) stale_left--;
                else wbm_ack_i = 1'b0;
            end else if (s_cyc && !unmapped(s_adr)) begin
                if (wait_cnt >= cur_delay) begin
                    wbm_ack_i = 1'b1;
                    wait_cnt = 0;
                    stale_left = (stale_mode == 2) ? 1 : (stale_mode == 1) ? $urandom_range(1, 0) : 0;
                    if (s_we) begin
                        resp_mem[s_adr[7:2]] = merge(resp_mem[s_adr[7:2]], s_dat, s_sel);
                        wbm_dat_i = $urandom;
                    end else begin
                        wbm_dat_i = resp_mem[s_adr[7:2]];
                    end
                end else begin
                    wait_cnt++;
                end
            end else begin
                wait_cnt = 0;
                if (!s_cyc) cur_delay = $urandom_range(dly_hi, dly_lo);
            end
        end
    end

    // ---------------- scoreboard: accepted commands ----------------
    logic [CMD_W-1:0] exp_q[$];
    initial begin
        forever begin
            @(posedge clk);
            if (wb_rst_i) exp_q.delete();
            else if (cmd_valid && cmd_ready)
                exp_q.push_back({cmd_we, cmd_sel, cmd_adr, cmd_dat});
        end
    end

    // ---------------- model + per-cycle compare ----------------
    logic [31:0] exp_mem [64];
    initial begin
        wb_cmd_t cur;
        logic in_flight, expect_rsp, prev_cyc, exp_err, busy_exp;
        logic [31:0] exp_dat;
        int cyc_len, low_len;
        for (int i = 0; i < 64; i++) exp_mem[i] = '0;
        cur = '0; in_flight = 0; expect_rsp = 0; prev_cyc = 0;
        exp_err = 0; exp_dat = '0; cyc_len = 0; low_len = 99;
        forever begin
            @(negedge clk);
            if (rsp_valid) rsp_seen++;
            if (wb_rst_i) begin
                in_flight = 0; expect_rsp = 0; prev_cyc = 0; low_len = 99;
            end else begin
                chk("cyc_eq_stb", wbm_stb_o, wbm_cyc_o);
                busy_exp = (exp_q.size() != 0) || in_flight;
                chk("busy", busy, busy_exp);
                if (expect_rsp) begin
                    chk("rsp_valid_after_end", rsp_valid, 1'b1);
                    chk("cyc_low_after_end", wbm_cyc_o, 1'b0);
                    chk("rsp_err", rsp_err, exp_err);
                    chk("rsp_dat", rsp_dat, exp_dat);
                    if (!exp_err && cur.we)
                        exp_mem[cur.adr[7:2]] = merge(exp_mem[cur.adr[7:2]], cur.dat, cur.sel);
                    expect_rsp = 0; in_flight = 0;
                end else begin
                    chk("no_spurious_rsp", rsp_valid, 1'b0);
                    if (in_flight && !wbm_cyc_o) begin
                        chk("cyc_held_until_end", wbm_cyc_o, 1'b1);
                        in_flight = 0;
                    end
                end
                if (wbm_cyc_o) begin
                    if (!prev_cyc) begin
                        chk("idle_gap_ge2", (low_len >= 2), 1'b1);
                        chk("cycle_has_cmd", (exp_q.size() != 0), 1'b1);
                        cur = (exp_q.size() != 0) ? wb_cmd_t'(exp_q.pop_front()) : '0;
                        in_flight = 1; cyc_len = 0;
                    end
                    chk("bus_we", wbm_we_o, cur.we);
                    chk("bus_sel", wbm_sel_o, cur.sel);
                    chk("bus_adr", wbm_adr_o, cur.adr);
                    chk("bus_dat", wbm_dat_o, cur.dat);
                    cyc_len++;
                    if (wbm_ack_i) begin
                        expect_rsp = 1; exp_err = 0;
                        exp_dat = cur.we ? 32'h0 : exp_mem[cur.adr[7:2]];
                    end else if (cyc_len == TMO) begin
                        expect_rsp = 1; exp_err = 1; exp_dat = 32'h0;
                    end
                    low_len = 0;
                end else begin
                    low_len++;
                end
                chk("cmd_ready", cmd_ready, (exp_q.size() < DEPTH));
                prev_cyc = wbm_cyc_o;
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat);
        int n;
        cmd_valid = 1'b1; cmd_we = we; cmd_sel = sel; cmd_adr = adr; cmd_dat = dat;
        n = 0;
        while (1) begin
            @(negedge clk);
            if (cmd_ready) begin
                @(posedge clk);
                break;
            end
            n++;
            if (n > 200) begin
                chk("send_ready_wait", cmd_ready, 1'b1);
                break;
            end
        end
        #1;
        cmd_valid = 1'b0;
    endtask

    // Counts edges from the call until rsp_valid, and cycles with cyc high.
    task automatic wait_rsp(output int n, output int cc, output logic err, output logic [31:0] dat);
        n = 0; cc = 0; err = 1'bx; dat = 'x;
        for (int i = 0; i < 200; i++) begin
            @(posedge clk); #1;
            n++;
            if (rsp_valid) begin
                err = rsp_err; dat = rsp_dat;
                return;
            end
            if (wbm_cyc_o) cc++;
        end
        chk("rsp_wait", rsp_valid, 1'b1);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 5000; i++) begin
            @(posedge clk); #1;
            if (!busy) return;
        end
        chk("drain_wait", busy, 1'b0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int n, cc, base;
        logic err;
        logic [31:0] dat, adr;
        logic e_err [5];
        logic [31:0] e_dat [5];

        repeat (3) @(posedge clk);
        #1 wb_rst_i = 1'b0;
        chk("rst_cyc", wbm_cyc_o, 1'b0);
        chk("rst_stb", wbm_stb_o, 1'b0);
        chk("rst_we", wbm_we_o, 1'b0);
        chk("rst_sel", wbm_sel_o, 4'h0);
        chk("rst_adr", wbm_adr_o, 32'h0);
        chk("rst_dat_o", wbm_dat_o, 32'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_err", rsp_err, 1'b0);
        chk("rst_rsp_dat", rsp_dat, 32'h0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_cmd_ready", cmd_ready, 1'b1);
        chk("rst_state", dbg_state, ST_IDLE);

        // write then read back against a registered-ack responder
        send(1'b1, 4'hF, 32'h3000_0000, 32'h0000_0002);
        wait_rsp(n, cc, err, dat);
        chk("wr_latency_edges", n, 3);
        chk("wr_cyc_cycles", cc, 2);
        chk("wr_err", err, 1'b0);
        chk("wr_dat", dat, 32'h0);
        send(1'b0, 4'hF, 32'h3000_0000, 32'hDEAD_BEEF);
        wait_rsp(n, cc, err, dat);
        chk("rd_err", err, 1'b0);
        chk("rd_dat", dat, 32'h0000_0002);

        // timeout on unmapped address
        send(1'b0, 4'hF, 32'h3000_0300, 32'h0);
        wait_rsp(n, cc, err, dat);
        chk("tmo_cyc_cycles", cc, TMO);
        chk("tmo_err", err, 1'b1);
        chk("tmo_dat", dat, 32'h0);
        wait_idle();

        // occupy the bus with a timeout, then fill the FIFO behind it
        send(1'b0, 4'hF, 32'h3000_0304, 32'h0);
        send(1'b1, 4'hF, 32'h3000_0010, 32'hA5A5_0001);
        send(1'b0, 4'hF, 32'h3000_0010, 32'h0);
        send(1'b1, 4'h3, 32'h3000_0014, 32'h1234_5678);
        send(1'b0, 4'hF, 32'h3000_0014, 32'h0);
        chk("full_cmd_ready", cmd_ready, 1'b0);
        e_err = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        e_dat = '{32'h0, 32'h0, 32'hA5A5_0001, 32'h0, 32'h0000_5678};
        for (int i = 0; i < 5; i++) begin
            wait_rsp(n, cc, err, dat);
            chk($sformatf("fill_err%0d", i), err, e_err[i]);
            chk($sformatf("fill_dat%0d", i), dat, e_dat[i]);
        end
        wait_idle();

        // stale ack held across GAP
        stale_mode = 2;
        base = rsp_seen;
        send(1'b1, 4'hF, 32'h3000_0020, 32'h1111_1111);
        send(1'b1, 4'hF, 32'h3000_0024, 32'h2222_2222);
        send(1'b0, 4'hF, 32'h3000_0020, 32'h0);
        wait_idle();
        repeat (4) @(posedge clk);
        #1 chk("stale_rsp_count", rsp_seen - base, 3);
        stale_mode = 0;

        // reset while in BUS with two commands queued
        dly_lo = 5; dly_hi = 5;
        send(1'b0, 4'hF, 32'h3000_0000, 32'h0);
        send(1'b0, 4'hF, 32'h3000_0004, 32'h0);
        send(1'b0, 4'hF, 32'h3000_0008, 32'h0);
        chk("pre_reset_cyc", wbm_cyc_o, 1'b1);
        base = rsp_seen;
        wb_rst_i = 1'b1;
        @(posedge clk);
        #1 wb_rst_i = 1'b0;
        chk("mid_rst_cyc", wbm_cyc_o, 1'b0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_cmd_ready", cmd_ready, 1'b1);
        repeat (15) @(posedge clk);
        #1 chk("mid_rst_no_rsp", rsp_seen - base, 0);
        dly_lo = 0; dly_hi = 0;
        send(1'b0, 4'hF, 32'h3000_0000, 32'h0);
        wait_rsp(n, cc, err, dat);
        chk("post_rst_err", err, 1'b0);
        chk("post_rst_dat", dat, 32'h0000_0002);

        // randomized traffic with ack delays 0-5 and random stale acks
        dly_lo = 0; dly_hi = 5; stale_mode = 1;
        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(99, 0) < 8) adr = 32'h3000_0300 | {24'h0, 2'($urandom_range(3, 0)), 6'h0};
            else adr = 32'h3000_0000 | {24'h0, 6'($urandom_range(63, 0)), 2'b00};
            send(1'($urandom_range(1, 0)), 4'($urandom_range(15, 0)), adr, $urandom);
            repeat ($urandom_range(3, 0)) @(posedge clk);
            #1;
        end
        wait_idle();
        repeat (4) @(posedge clk);
        #1 chk("final_queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
